// File: rtl/axi_reg_slice_pkg.sv
// Shared AXI channel payload structs and port bundles used by axi_reg_slice and axi_ram,
// plus the occupancy encoding of the skid-buffer slices.
package axi_reg_slice_pkg;

    localparam int AXI_ID_W_WIDTH = 4;
    localparam int AXI_ID_R_WIDTH = 4;
    localparam int AXI_ADDR_WIDTH = 16;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    localparam logic [1:0] SLICE_EMPTY = 2'd0;
    localparam logic [1:0] SLICE_ONE   = 2'd1;
    localparam logic [1:0] SLICE_FULL  = 2'd2;

    typedef struct packed {
        logic [AXI_ID_W_WIDTH-1:0] id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
    } axi_aw_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [AXI_STRB_WIDTH-1:0] strb;
        logic                      last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_R_WIDTH-1:0] id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
    } axi_ar_t;

    typedef struct packed {
        logic [AXI_ID_W_WIDTH-1:0] id;
        logic [1:0]                resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_R_WIDTH-1:0] id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
    } axi_r_t;

    typedef struct packed {
        axi_aw_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        axi_ar_t ar;
        logic    ar_valid;
        logic    b_ready;
        logic    r_ready;
    } axis_mosi_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        logic    ar_ready;
        axi_b_t  b;
        logic    b_valid;
        axi_r_t  r;
        logic    r_valid;
    } axis_miso_t;

endpackage

// File: rtl/axi_reg_slice_skid.sv
// Two-entry skid buffer: every output (valid, ready, payload) comes straight from a flop,
// so a slice breaks all combinational paths between its two sides.
module axi_skid_buf
    import axi_reg_slice_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       r_state;
    logic             r_outValid;
    logic             r_inReady;
    logic [WIDTH-1:0] r_outData;
    logic [WIDTH-1:0] r_skidData;

    logic [1:0]       w_stateNext;
    logic             w_inHs;
    logic             w_outHs;
    logic             w_loadOutFromIn;
    logic             w_loadOutFromSkid;
    logic             w_loadSkid;

    assign w_inHs  = in_valid & r_inReady;
    assign w_outHs = r_outValid & out_ready;

    // Occupancy transitions and which payload register captures on this edge.
    always_comb begin
        w_stateNext       = r_state;
        w_loadOutFromIn   = 1'b0;
        w_loadOutFromSkid = 1'b0;
        w_loadSkid        = 1'b0;
        case (r_state)
            SLICE_EMPTY: begin
                if (w_inHs) begin
                    w_stateNext     = SLICE_ONE;
                    w_loadOutFromIn = 1'b1;
                end
            end
            SLICE_ONE: begin
                if (w_inHs && w_outHs) begin
                    w_loadOutFromIn = 1'b1;
                end else if (w_inHs) begin
                    w_stateNext = SLICE_FULL;
                    w_loadSkid  = 1'b1;
                end else if (w_outHs) begin
                    w_stateNext = SLICE_EMPTY;
                end
            end
            SLICE_FULL: begin
                if (w_outHs) begin
                    w_stateNext       = SLICE_ONE;
                    w_loadOutFromSkid = 1'b1;
                end
            end
            default: w_stateNext = SLICE_EMPTY;
        endcase
    end

    // Valid and ready are registered copies of the next occupancy, not decoded from r_state.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state    <= SLICE_EMPTY;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_outValid <= (w_stateNext != SLICE_EMPTY);
            r_inReady  <= (w_stateNext != SLICE_FULL);
        end
    end

    // Payload registers are deliberately unreset; they are only meaningful while valid is high.
    always_ff @(posedge clk_in) begin
        if (w_loadOutFromIn) begin
            r_outData <= in_data;
        end else if (w_loadOutFromSkid) begin
            r_outData <= r_skidData;
        end
        if (w_loadSkid) begin
            r_skidData <= in_data;
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;

endmodule

// File: rtl/axi_reg_slice.sv
// Full AXI register slice between a NoC master port and axi_ram: five independent
// skid-buffer slices, AW/W/AR forward and B/R reverse, with no coupling between channels.
module axi_reg_slice
    import axi_reg_slice_pkg::*;
#(
    parameter int ID_W_WIDTH = 4,
    parameter int ID_R_WIDTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk_in,
    input  logic       rst,
    input  axis_mosi_t s_mosi_i,
    output axis_miso_t s_miso_o,
    output axis_mosi_t m_mosi_o,
    input  axis_miso_t m_miso_i
);

    // The channel structs are shared with axi_ram, so the parameters can only confirm them.
    if (ID_W_WIDTH != AXI_ID_W_WIDTH || ID_R_WIDTH != AXI_ID_R_WIDTH ||
        ADDR_WIDTH != AXI_ADDR_WIDTH || DATA_WIDTH != AXI_DATA_WIDTH) begin : g_badParams
        $error("axi_reg_slice: parameters must match the shared AXI package widths");
    end

    logic    w_awReady, w_awValid;
    logic    w_wReady,  w_wValid;
    logic    w_arReady, w_arValid;
    logic    w_bReady,  w_bValid;
    logic    w_rReady,  w_rValid;
    axi_aw_t w_awData;
    axi_w_t  w_wData;
    axi_ar_t w_arData;
    axi_b_t  w_bData;
    axi_r_t  w_rData;

    axi_skid_buf #(.WIDTH($bits(axi_aw_t))) u_awSlice (
        .clk_in    (clk_in),
        .rst       (rst),
        .in_valid  (s_mosi_i.aw_valid),
        .in_ready  (w_awReady),
        .in_data   (s_mosi_i.aw),
        .out_valid (w_awValid),
        .out_ready (m_miso_i.aw_ready),
        .out_data  (w_awData)
    );

    axi_skid_buf #(.WIDTH($bits(axi_w_t))) u_wSlice (
        .clk_in    (clk_in),
        .rst       (rst),
        .in_valid  (s_mosi_i.w_valid),
        .in_ready  (w_wReady),
        .in_data   (s_mosi_i.w),
        .out_valid (w_wValid),
        .out_ready (m_miso_i.w_ready),
        .out_data  (w_wData)
    );

    axi_skid_buf #(.WIDTH($bits(axi_ar_t))) u_arSlice (
        .clk_in    (clk_in),
        .rst       (rst),
        .in_valid  (s_mosi_i.ar_valid),
        .in_ready  (w_arReady),
        .in_data   (s_mosi_i.ar),
        .out_valid (w_arValid),
        .out_ready (m_miso_i.ar_ready),
        .out_data  (w_arData)
    );

    axi_skid_buf #(.WIDTH($bits(axi_b_t))) u_bSlice (
        .clk_in    (clk_in),
        .rst       (rst),
        .in_valid  (m_miso_i.b_valid),
        .in_ready  (w_bReady),
        .in_data   (m_miso_i.b),
        .out_valid (w_bValid),
        .out_ready (s_mosi_i.b_ready),
        .out_data  (w_bData)
    );

    axi_skid_buf #(.WIDTH($bits(axi_r_t))) u_rSlice (
        .clk_in    (clk_in),
        .rst       (rst),
        .in_valid  (m_miso_i.r_valid),
        .in_ready  (w_rReady),
        .in_data   (m_miso_i.r),
        .out_valid (w_rValid),
        .out_ready (s_mosi_i.r_ready),
        .out_data  (w_rData)
    );

    // Reassemble the port bundles from the slice outputs.
    always_comb begin
        m_mosi_o          = '0;
        m_mosi_o.aw       = w_awData;
        m_mosi_o.aw_valid = w_awValid;
        m_mosi_o.w        = w_wData;
        m_mosi_o.w_valid  = w_wValid;
        m_mosi_o.ar       = w_arData;
        m_mosi_o.ar_valid = w_arValid;
        m_mosi_o.b_ready  = w_bReady;
        m_mosi_o.r_ready  = w_rReady;

        s_miso_o          = '0;
        s_miso_o.aw_ready = w_awReady;
        s_miso_o.w_ready  = w_wReady;
        s_miso_o.ar_ready = w_arReady;
        s_miso_o.b        = w_bData;
        s_miso_o.b_valid  = w_bValid;
        s_miso_o.r        = w_rData;
        s_miso_o.r_valid  = w_rValid;
    end

endmodule

// File: tb/tb_axi_reg_slice.sv
// Self-checking bench for axi_reg_slice: scripted W-slice vectors, directed multi-cycle
// sequences, and a randomized run against a per-channel FIFO model of capacity two.
`timescale 1ns/1ps
module tb_axi_reg_slice;
    import axi_reg_slice_pkg::*;

    localparam int AW_BITS       = $bits(axi_aw_t);
    localparam int W_BITS        = $bits(axi_w_t);
    localparam int AR_BITS       = $bits(axi_ar_t);
    localparam int B_BITS        = $bits(axi_b_t);
    localparam int R_BITS        = $bits(axi_r_t);
    localparam int NUM_CH        = 5;
    localparam int RANDOM_CYCLES = 10000;

    typedef logic [63:0] beat_t;

    typedef struct {
        logic        inValid;
        logic [31:0] inData;
        logic        outReady;
        logic        expInReady;
        logic        expOutValid;
        logic [31:0] expOutData;
    } wVec_t;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    axis_mosi_t sMosi;
    axis_miso_t sMiso;
    axis_mosi_t mMosi;
    axis_miso_t mMiso;

    int checkCount = 0;
    int passCount  = 0;

    axi_reg_slice #(
        .ID_W_WIDTH (AXI_ID_W_WIDTH),
        .ID_R_WIDTH (AXI_ID_R_WIDTH),
        .ADDR_WIDTH (AXI_ADDR_WIDTH),
        .DATA_WIDTH (AXI_DATA_WIDTH)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .s_mosi_i (sMosi),
        .s_miso_o (sMiso),
        .m_mosi_o (mMosi),
        .m_miso_i (mMiso)
    );

    always #5 clk_in = ~clk_in;

    // Channel index: 0=AW 1=W 2=AR (forward), 3=B 4=R (reverse).
    function automatic int chanBits(input int c);
        case (c)
            0:       return AW_BITS;
            1:       return W_BITS;
            2:       return AR_BITS;
            3:       return B_BITS;
            default: return R_BITS;
        endcase
    endfunction

    function automatic beat_t widthMask(input int c);
        return (64'd1 << chanBits(c)) - 64'd1;
    endfunction

    function automatic logic inReady(input int c);
        case (c)
            0:       return sMiso.aw_ready;
            1:       return sMiso.w_ready;
            2:       return sMiso.ar_ready;
            3:       return mMosi.b_ready;
            default: return mMosi.r_ready;
        endcase
    endfunction

    function automatic logic outValid(input int c);
        case (c)
            0:       return mMosi.aw_valid;
            1:       return mMosi.w_valid;
            2:       return mMosi.ar_valid;
            3:       return sMiso.b_valid;
            default: return sMiso.r_valid;
        endcase
    endfunction

    function automatic beat_t outData(input int c);
        beat_t v;
        v = '0;
        case (c)
            0:       v[AW_BITS-1:0] = mMosi.aw;
            1:       v[W_BITS-1:0]  = mMosi.w;
            2:       v[AR_BITS-1:0] = mMosi.ar;
            3:       v[B_BITS-1:0]  = sMiso.b;
            default: v[R_BITS-1:0] = sMiso.r;
        endcase
        return v;
    endfunction

    function automatic logic [4:0] allValids();
        return {mMosi.aw_valid, mMosi.w_valid, mMosi.ar_valid, sMiso.b_valid, sMiso.r_valid};
    endfunction

    function automatic logic [4:0] allReadies();
        return {sMiso.aw_ready, sMiso.w_ready, sMiso.ar_ready, mMosi.b_ready, mMosi.r_ready};
    endfunction

    function automatic beat_t wBeat(input int d, input logic last);
        axi_w_t wb;
        beat_t  v;
        wb.data = d;
        wb.strb = '1;
        wb.last = last;
        v = '0;
        v[W_BITS-1:0] = wb;
        return v;
    endfunction

    function automatic beat_t arBeat(input int i);
        axi_ar_t ab;
        beat_t   v;
        ab.id    = i[AXI_ID_R_WIDTH-1:0];
        ab.addr  = 16'h0100 + i[15:0] * 16'd4;
        ab.len   = 8'd0;
        ab.size  = 3'd2;
        ab.burst = 2'd1;
        v = '0;
        v[AR_BITS-1:0] = ab;
        return v;
    endfunction

    function automatic beat_t rBeat(input int i);
        axi_r_t rb;
        beat_t  v;
        rb.id   = i[AXI_ID_R_WIDTH-1:0];
        rb.data = 100 + i;
        rb.resp = 2'd0;
        rb.last = (i == 3);
        v = '0;
        v[R_BITS-1:0] = rb;
        return v;
    endfunction

    // Drives one channel's upstream valid/payload and its downstream ready.
    task automatic applyStimulus(input int c, input logic v, input beat_t data, input logic oReady);
        case (c)
            0: begin sMosi.aw_valid = v; sMosi.aw = data[AW_BITS-1:0]; mMiso.aw_ready = oReady; end
            1: begin sMosi.w_valid  = v; sMosi.w  = data[W_BITS-1:0];  mMiso.w_ready  = oReady; end
            2: begin sMosi.ar_valid = v; sMosi.ar = data[AR_BITS-1:0]; mMiso.ar_ready = oReady; end
            3: begin mMiso.b_valid  = v; mMiso.b  = data[B_BITS-1:0];  sMosi.b_ready  = oReady; end
            default: begin mMiso.r_valid = v; mMiso.r = data[R_BITS-1:0]; sMosi.r_ready = oReady; end
        endcase
    endtask

    task automatic idleAll();
        for (int c = 0; c < NUM_CH; c++) begin
            applyStimulus(c, 1'b0, '0, 1'b1);
        end
    endtask

    task automatic checkOutput(input string name, input beat_t actual, input beat_t expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        wVec_t    vecs [12];
        beat_t    mem [NUM_CH][8];
        int       wrPtr [NUM_CH];
        int       rdPtr [NUM_CH];
        logic     prevV [NUM_CH];
        logic     prevR [NUM_CH];
        beat_t    prevD [NUM_CH];
        beat_t    awExp;
        axi_aw_t  awb;
        axi_b_t   bb;
        beat_t    bBeat;
        beat_t    d;
        int       occ;
        int       srcIdx;
        int       got;
        logic     iV;
        logic     oR;
        logic     rReady;

        sMosi = '0;
        mMiso = '0;
        idleAll();

        // ---------------- reset state and first AW beat ----------------
        repeat (2) @(negedge clk_in);
        checkOutput("reset valids", allValids(), 5'b00000);
        checkOutput("reset readies", allReadies(), 5'b00000);
        rst = 1'b0;
        @(negedge clk_in);
        checkOutput("release readies", allReadies(), 5'b11111);
        checkOutput("release valids", allValids(), 5'b00000);
        @(negedge clk_in);
        awb.id = 4'd3; awb.addr = 16'h0040; awb.len = 8'd3; awb.size = 3'd2; awb.burst = 2'd1;
        awExp = '0;
        awExp[AW_BITS-1:0] = awb;
        checkOutput("aw ready before beat", sMiso.aw_ready, 1'b1);
        checkOutput("aw valid before beat", mMosi.aw_valid, 1'b0);
        applyStimulus(0, 1'b1, awExp, 1'b1);
        @(negedge clk_in);
        checkOutput("aw valid after 1 cycle", mMosi.aw_valid, 1'b1);
        checkOutput("aw payload", outData(0), awExp);
        checkOutput("aw ready held", sMiso.aw_ready, 1'b1);
        applyStimulus(0, 1'b0, '0, 1'b1);
        @(negedge clk_in);
        checkOutput("aw drained", mMosi.aw_valid, 1'b0);

        // ---------------- W slice occupancy vectors ----------------
        vecs[0]  = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'hB2, 1'b0, 1'b1, 1'b1, 32'hA1};
        vecs[2]  = '{1'b1, 32'hC3, 1'b0, 1'b0, 1'b1, 32'hA1};
        vecs[3]  = '{1'b1, 32'hC3, 1'b1, 1'b0, 1'b1, 32'hA1};
        vecs[4]  = '{1'b1, 32'hC3, 1'b1, 1'b1, 1'b1, 32'hB2};
        vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hC3};
        vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'hD4, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'hE5, 1'b0, 1'b1, 1'b1, 32'hD4};
        vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hD4};
        vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hE5};
        vecs[11] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0};
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            checkOutput($sformatf("vec%0d w_ready", k), sMiso.w_ready, vecs[k].expInReady);
            checkOutput($sformatf("vec%0d w_valid", k), mMosi.w_valid, vecs[k].expOutValid);
            if (vecs[k].expOutValid) begin
                checkOutput($sformatf("vec%0d w_data", k), mMosi.w.data, vecs[k].expOutData);
            end
            applyStimulus(1, vecs[k].inValid, wBeat(vecs[k].inData, 1'b0), vecs[k].outReady);
        end
        applyStimulus(1, 1'b0, '0, 1'b1);

        // ---------------- W stream of 16 beats, no bubbles ----------------
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk_in);
            if (k > 0) begin
                checkOutput($sformatf("wstream%0d valid", k - 1), mMosi.w_valid, 1'b1);
                checkOutput($sformatf("wstream%0d data", k - 1), mMosi.w.data, k - 1);
                checkOutput($sformatf("wstream%0d last", k - 1), mMosi.w.last, (k == 16));
            end
            checkOutput($sformatf("wstream%0d ready", k), sMiso.w_ready, 1'b1);
            applyStimulus(1, (k < 16), wBeat(k, (k == 15)), 1'b1);
        end
        @(negedge clk_in);
        checkOutput("wstream drained", mMosi.w_valid, 1'b0);

        // ---------------- AR pass-through while holding one entry ----------------
        applyStimulus(2, 1'b1, arBeat(0), 1'b0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_in);
            checkOutput($sformatf("ar one%0d ready", i), sMiso.ar_ready, 1'b1);
            checkOutput($sformatf("ar one%0d valid", i), mMosi.ar_valid, 1'b1);
            checkOutput($sformatf("ar one%0d data", i), outData(2), arBeat(i - 1));
            applyStimulus(2, 1'b1, arBeat(i), 1'b1);
        end
        @(negedge clk_in);
        checkOutput("ar last beat", outData(2), arBeat(8));
        applyStimulus(2, 1'b0, '0, 1'b1);
        @(negedge clk_in);
        checkOutput("ar drained", mMosi.ar_valid, 1'b0);

        // ---------------- R backpressure from the master side ----------------
        srcIdx = 0;
        got    = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk_in);
            rReady = mMosi.r_ready;
            applyStimulus(4, (srcIdx < 4), rBeat(srcIdx), 1'b0);
            if (srcIdx < 4 && rReady) srcIdx++;
        end
        @(negedge clk_in);
        checkOutput("r accepted while stalled", srcIdx, 2);
        checkOutput("r slave ready dropped", mMosi.r_ready, 1'b0);
        checkOutput("r valid held", sMiso.r_valid, 1'b1);
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            if (cyc > 0) @(negedge clk_in);
            if (sMiso.r_valid) begin
                checkOutput($sformatf("r beat%0d", got), outData(4), rBeat(got));
                got++;
            end
            rReady = mMosi.r_ready;
            applyStimulus(4, (srcIdx < 4), rBeat(srcIdx), 1'b1);
            if (srcIdx < 4 && rReady) srcIdx++;
        end
        checkOutput("r beats delivered", got, 4);
        applyStimulus(4, 1'b0, '0, 1'b1);
        @(negedge clk_in);
        checkOutput("r no duplicate", sMiso.r_valid, 1'b0);

        // ---------------- reset with W full and B holding one ----------------
        bb.id = 4'd5; bb.resp = 2'd2;
        bBeat = '0;
        bBeat[B_BITS-1:0] = bb;
        @(negedge clk_in);
        applyStimulus(1, 1'b1, wBeat(32'h11, 1'b0), 1'b0);
        applyStimulus(3, 1'b1, bBeat, 1'b0);
        @(negedge clk_in);
        applyStimulus(1, 1'b1, wBeat(32'h22, 1'b1), 1'b0);
        applyStimulus(3, 1'b0, '0, 1'b0);
        @(negedge clk_in);
        applyStimulus(1, 1'b0, '0, 1'b0);
        checkOutput("pre-reset w full", sMiso.w_ready, 1'b0);
        checkOutput("pre-reset w valid", mMosi.w_valid, 1'b1);
        checkOutput("pre-reset b valid", sMiso.b_valid, 1'b1);
        checkOutput("pre-reset b room", mMosi.b_ready, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("async reset valids", allValids(), 5'b00000);
        checkOutput("async reset readies", allReadies(), 5'b00000);
        idleAll();
        @(negedge clk_in);
        checkOutput("held reset valids", allValids(), 5'b00000);
        rst = 1'b0;
        @(negedge clk_in);
        checkOutput("post-reset readies", allReadies(), 5'b11111);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            checkOutput($sformatf("no stale beat %0d", k), allValids(), 5'b00000);
        end

        // ---------------- randomized traffic on all five channels ----------------
        for (int c = 0; c < NUM_CH; c++) begin
            wrPtr[c] = 0;
            rdPtr[c] = 0;
            prevV[c] = 1'b0;
            prevR[c] = 1'b0;
            prevD[c] = '0;
        end
        for (int cyc = 0; cyc < RANDOM_CYCLES; cyc++) begin
            @(negedge clk_in);
            for (int c = 0; c < NUM_CH; c++) begin
                occ = wrPtr[c] - rdPtr[c];
                if (prevV[c] && !prevR[c]) begin
                    checkOutput($sformatf("ch%0d stable valid", c), outValid(c), 1'b1);
                    checkOutput($sformatf("ch%0d stable data", c), outData(c), prevD[c]);
                end
                checkOutput($sformatf("ch%0d in_ready", c), inReady(c), (occ < 2));
                checkOutput($sformatf("ch%0d out_valid", c), outValid(c), (occ > 0));
                iV = ($urandom_range(0, 99) < 60);
                oR = ($urandom_range(0, 99) < ((cyc < RANDOM_CYCLES / 2) ? 40 : 85));
                d  = {$urandom, $urandom} & widthMask(c);
                if (outValid(c) && oR) begin
                    checkOutput($sformatf("ch%0d order", c), outData(c), mem[c][rdPtr[c] % 8]);
                    rdPtr[c]++;
                end
                if (iV && inReady(c)) begin
                    mem[c][wrPtr[c] % 8] = d;
                    wrPtr[c]++;
                end
                applyStimulus(c, iV, d, oR);
                prevV[c] = outValid(c);
                prevR[c] = oR;
                prevD[c] = outData(c);
            end
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
